// File: rtl/alu_multicycle_pkg.sv
// rtl/alu_multicycle_pkg.sv - opcode/state types and opcode classification helpers
// Purpose: shared types for alu_multicycle and its iterative mul/div engine.
// Contents: alu_opcode_e, alu_state_e, is_muldiv(), is_div_op(), is_signed_md().
package alu_multicycle_pkg;

    typedef enum logic [4:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLTS,
        ALU_SLTU,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_MUL,
        ALU_MULH,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU
    } alu_opcode_e;

    typedef enum logic [1:0] {
        ALU_IDLE,
        ALU_BUSY,
        ALU_FIX
    } alu_state_e;

    function automatic logic is_muldiv(input alu_opcode_e op);
        return op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    function automatic logic is_div_op(input alu_opcode_e op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    // Ops whose operands are interpreted as two's complement before magnitude capture.
    // MUL is included: the low product half is the same either way.
    function automatic logic is_signed_md(input alu_opcode_e op);
        return op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
    endfunction

endpackage

// File: rtl/alu_multicycle_muldiv_iter.sv
// rtl/alu_multicycle_muldiv_iter.sv - radix-2 shift-add multiplier / restoring divider
// Purpose: WIDTH-step unsigned engine on a shared 2*WIDTH accumulator.
// Ports: clk, reset (async, active-high), start_i loads operands, is_div_i selects divide,
//        a_mag_i/b_mag_i unsigned operands, done_o high during the last step cycle,
//        acc_o = product (mul) or {remainder, quotient} (div).
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic                 is_div_i,
    input  logic [WIDTH-1:0]     a_mag_i,
    input  logic [WIDTH-1:0]     b_mag_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   acc_o
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q;
    logic               is_div_q;
    logic               run_q;
    logic [CW-1:0]      cnt_q;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic               ge;

    always_comb begin
        // Multiply: add multiplicand into the high half when the current multiplier
        // bit (acc[0]) is set, then shift the whole accumulator right, carry included.
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        // Divide: shift the next dividend bit into the partial remainder; the extra
        // top bit keeps the bit shifted out of the remainder half.
        rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff    = rem_sh - {1'b0, b_q};
        ge      = ~diff[WIDTH];
        if (is_div_q) begin
            acc_d = {(ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            run_q    <= 1'b0;
            cnt_q    <= '0;
        end else if (start_i) begin
            acc_q    <= {{WIDTH{1'b0}}, a_mag_i};
            b_q      <= b_mag_i;
            is_div_q <= is_div_i;
            run_q    <= 1'b1;
            cnt_q    <= '0;
        end else if (run_q) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                run_q <= 1'b0;
            end
        end
    end

    assign done_o = run_q && (cnt_q == CW'(WIDTH - 1));
    assign acc_o  = acc_q;

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - ALU with single-cycle ops and iterative mul/div
// Purpose: issue handshake, single-cycle datapath, sign handling, FSM and output registers.
// Ports: clk, reset (async, active-high); alu_enable_ip/alu_operator_ip/alu_operand_a_ip/
//        alu_operand_b_ip issue; alu_flush_ip abort; alu_ready_op accept window;
//        alu_result_op/alu_valid_op/alu_illegal_op completion.
module alu_multicycle
    import alu_multicycle_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1,
    parameter bit DIV_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_enable_ip,
    input  alu_opcode_e       alu_operator_ip,
    input  logic [WIDTH-1:0]  alu_operand_a_ip,
    input  logic [WIDTH-1:0]  alu_operand_b_ip,
    input  logic              alu_flush_ip,
    output logic              alu_ready_op,
    output logic [WIDTH-1:0]  alu_result_op,
    output logic              alu_valid_op,
    output logic              alu_illegal_op
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_e         state_q, state_d;
    alu_opcode_e        op_q, op_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               b_zero_q, b_zero_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               valid_q, valid_d;
    logic               illegal_q, illegal_d;

    logic               accept;
    logic               op_md;
    logic               op_legal;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   sc_result;
    logic [SHW-1:0]     shamt;
    logic               md_done;
    logic [2*WIDTH-1:0] md_acc;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   fix_result;

    assign alu_ready_op = (state_q == ALU_IDLE);
    assign accept       = alu_enable_ip && alu_ready_op && !alu_flush_ip;
    assign op_md        = is_muldiv(alu_operator_ip);

    always_comb begin
        op_legal = 1'b1;
        if (op_md) begin
            op_legal = is_div_op(alu_operator_ip) ? DIV_EN : MUL_EN;
        end else if (alu_operator_ip > ALU_SRA) begin
            op_legal = 1'b0;
        end
    end

    assign a_neg = is_signed_md(alu_operator_ip) && alu_operand_a_ip[WIDTH-1];
    assign b_neg = is_signed_md(alu_operator_ip) && alu_operand_b_ip[WIDTH-1];
    assign a_mag = a_neg ? -alu_operand_a_ip : alu_operand_a_ip;
    assign b_mag = b_neg ? -alu_operand_b_ip : alu_operand_b_ip;
    assign shamt = alu_operand_b_ip[SHW-1:0];

    always_comb begin
        sc_result = '0;
        case (alu_operator_ip)
            ALU_ADD:  sc_result = alu_operand_a_ip + alu_operand_b_ip;
            ALU_SUB:  sc_result = alu_operand_a_ip - alu_operand_b_ip;
            ALU_SLTS: sc_result = {{(WIDTH-1){1'b0}},
                                   ($signed(alu_operand_a_ip) < $signed(alu_operand_b_ip))};
            ALU_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (alu_operand_a_ip < alu_operand_b_ip)};
            ALU_AND:  sc_result = alu_operand_a_ip & alu_operand_b_ip;
            ALU_OR:   sc_result = alu_operand_a_ip | alu_operand_b_ip;
            ALU_XOR:  sc_result = alu_operand_a_ip ^ alu_operand_b_ip;
            ALU_SLL:  sc_result = alu_operand_a_ip << shamt;
            ALU_SRL:  sc_result = alu_operand_a_ip >> shamt;
            ALU_SRA:  sc_result = WIDTH'($signed(alu_operand_a_ip) >>> shamt);
            default:  sc_result = '0;
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk      (clk),
        .reset    (reset),
        .start_i  (accept && op_legal && op_md),
        .is_div_i (is_div_op(alu_operator_ip)),
        .a_mag_i  (a_mag),
        .b_mag_i  (b_mag),
        .done_o   (md_done),
        .acc_o    (md_acc)
    );

    // Sign correction applied in FIX. Divide-by-zero bypasses the quotient negation so the
    // result is all ones regardless of the dividend sign; the remainder comes back as A.
    always_comb begin
        prod       = (sign_a_q ^ sign_b_q) ? -md_acc : md_acc;
        quo        = md_acc[WIDTH-1:0];
        rem        = md_acc[2*WIDTH-1:WIDTH];
        fix_result = '0;
        case (op_q)
            ALU_MUL:  fix_result = prod[WIDTH-1:0];
            ALU_MULH: fix_result = prod[2*WIDTH-1:WIDTH];
            ALU_DIV:  fix_result = b_zero_q ? '1 : ((sign_a_q ^ sign_b_q) ? -quo : quo);
            ALU_REM:  fix_result = sign_a_q ? -rem : rem;
            ALU_DIVU: fix_result = quo;
            ALU_REMU: fix_result = rem;
            default:  fix_result = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        b_zero_d  = b_zero_q;
        result_d  = result_q;
        valid_d   = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            ALU_IDLE: begin
                if (accept) begin
                    if (!op_legal) begin
                        result_d  = '0;
                        valid_d   = 1'b1;
                        illegal_d = 1'b1;
                    end else if (op_md) begin
                        state_d  = ALU_BUSY;
                        op_d     = alu_operator_ip;
                        sign_a_d = a_neg;
                        sign_b_d = b_neg;
                        b_zero_d = (alu_operand_b_ip == '0);
                    end else begin
                        result_d = sc_result;
                        valid_d  = 1'b1;
                    end
                end
            end
            ALU_BUSY: begin
                if (alu_flush_ip) begin
                    state_d = ALU_IDLE;
                end else if (md_done) begin
                    state_d = ALU_FIX;
                end
            end
            ALU_FIX: begin
                state_d = ALU_IDLE;
                if (!alu_flush_ip) begin
                    result_d = fix_result;
                    valid_d  = 1'b1;
                end
            end
            default: state_d = ALU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ALU_IDLE;
            op_q      <= ALU_ADD;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            b_zero_q  <= 1'b0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            b_zero_q  <= b_zero_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    assign alu_result_op  = result_q;
    assign alu_valid_op   = valid_q;
    assign alu_illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - self-checking bench for alu_multicycle
module tb_alu_multicycle;
    import alu_multicycle_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        en, en2, flush;
    alu_opcode_e op;
    logic [31:0] a, b;
    logic        rdy, vld, ill;
    logic [31:0] res;
    logic        rdy2, vld2, ill2;
    logic [31:0] res2;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] last_res;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(32), .MUL_EN(1'b1), .DIV_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .alu_enable_ip(en), .alu_operator_ip(op),
        .alu_operand_a_ip(a), .alu_operand_b_ip(b), .alu_flush_ip(flush),
        .alu_ready_op(rdy), .alu_result_op(res), .alu_valid_op(vld), .alu_illegal_op(ill)
    );

    alu_multicycle #(.WIDTH(32), .MUL_EN(1'b0), .DIV_EN(1'b1)) dut_nomul (
        .clk(clk), .reset(reset), .alu_enable_ip(en2), .alu_operator_ip(op),
        .alu_operand_a_ip(a), .alu_operand_b_ip(b), .alu_flush_ip(flush),
        .alu_ready_op(rdy2), .alu_result_op(res2), .alu_valid_op(vld2), .alu_illegal_op(ill2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input alu_opcode_e o, input logic [31:0] x,
                                          input logic [31:0] y);
        int          sx, sy;
        longint      p;
        logic [63:0] pu;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            ALU_ADD:  return x + y;
            ALU_SUB:  return x - y;
            ALU_SLTS: return (sx < sy) ? 32'd1 : 32'd0;
            ALU_SLTU: return (x < y) ? 32'd1 : 32'd0;
            ALU_AND:  return x & y;
            ALU_OR:   return x | y;
            ALU_XOR:  return x ^ y;
            ALU_SLL:  return x << y[4:0];
            ALU_SRL:  return x >> y[4:0];
            ALU_SRA:  return sx >>> y[4:0];
            ALU_MUL: begin
                pu = {32'd0, x} * {32'd0, y};
                return pu[31:0];
            end
            ALU_MULH: begin
                p = longint'(sx) * longint'(sy);
                return p[63:32];
            end
            ALU_DIV: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sx / sy;
            end
            ALU_REM: begin
                if (y == 32'd0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                return sx % sy;
            end
            ALU_DIVU: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            ALU_REMU: return (y == 32'd0) ? x : x % y;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = $urandom_range(0, 40);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Issue one op at edge T, then find the completion and check latency, result, flags.
    task automatic run_op(input alu_opcode_e o, input logic [31:0] x, input logic [31:0] y,
                          input string tag);
        logic [31:0] exp;
        int          lat, k;
        logic        seen, bad_rdy;
        exp = model(o, x, y);
        lat = is_muldiv(o) ? 34 : 1;
        @(negedge clk);
        en = 1'b1; op = o; a = x; b = y;
        check({tag, " ready"}, 32'(rdy), 32'd1);
        @(posedge clk);
        #1 en = 1'b0;
        k = 0; seen = 1'b0; bad_rdy = 1'b0;
        while (k < 60 && !seen) begin
            @(negedge clk);
            k++;
            if (vld) seen = 1'b1;
            else if (rdy) bad_rdy = 1'b1;
            a = $urandom; b = $urandom;
        end
        check({tag, " latency"}, 32'(k), 32'(lat));
        check({tag, " result"}, res, exp);
        check({tag, " illegal"}, 32'(ill), 32'd0);
        if (lat > 1) check({tag, " ready low while busy"}, 32'(bad_rdy), 32'd0);
        last_res = exp;
    endtask

    initial begin
        logic        any_vld;
        alu_opcode_e ro;
        reset = 1'b1; en = 1'b0; en2 = 1'b0; flush = 1'b0;
        op = ALU_ADD; a = '0; b = '0;
        #12;
        check("reset result", res, 32'd0);
        check("reset valid", 32'(vld), 32'd0);
        check("reset illegal", 32'(ill), 32'd0);
        check("reset ready", 32'(rdy), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        run_op(ALU_ADD, 32'hFFFF_FFFF, 32'd1, "add wrap");
        run_op(ALU_SRA, 32'h8000_0000, 32'd4, "sra");
        check("sra literal", res, 32'hF800_0000);
        run_op(ALU_MUL, 32'd7, -32'sd3, "mul 7*-3");
        check("mul literal", res, 32'hFFFF_FFEB);
        run_op(ALU_MULH, 32'd7, -32'sd3, "mulh 7*-3");
        run_op(ALU_DIV, -32'sd7, 32'd2, "div -7/2");
        check("div literal", res, 32'hFFFF_FFFD);
        run_op(ALU_REM, -32'sd7, 32'd2, "rem -7/2");
        run_op(ALU_DIVU, 32'd7, 32'd0, "divu by 0");
        run_op(ALU_REM, 32'd7, 32'd0, "rem by 0");
        run_op(ALU_DIV, -32'sd9, 32'd0, "div neg by 0");
        run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div overflow");
        run_op(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, "rem overflow");
        run_op(ALU_SLTS, 32'hFFFF_FFFF, 32'd1, "slts");
        run_op(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, "sltu");
        run_op(ALU_SLL, 32'h0000_0001, 32'hFFFF_FFE5, "sll amt masked");

        for (int i = 0; i < 40; i++) begin
            ro = alu_opcode_e'($urandom_range(0, 15));
            run_op(ro, pick(), pick(), $sformatf("rand%0d %s", i, ro.name()));
        end

        // Back-to-back single-cycle issue.
        @(negedge clk);
        en = 1'b1; op = ALU_SUB; a = 32'd5; b = 32'd9;
        @(posedge clk);
        @(negedge clk);
        check("b2b first valid", 32'(vld), 32'd1);
        check("b2b first result", res, 32'hFFFF_FFFC);
        check("b2b ready", 32'(rdy), 32'd1);
        op = ALU_XOR; a = 32'hF0F0_0000; b = 32'h0FF0_00FF;
        @(posedge clk);
        #1 en = 1'b0;
        @(negedge clk);
        check("b2b second valid", 32'(vld), 32'd1);
        check("b2b second result", res, 32'hFF00_00FF);
        last_res = 32'hFF00_00FF;

        // Flush during BUSY: DIV accepted at T, flush sampled at T+10.
        @(negedge clk);
        en = 1'b1; op = ALU_DIV; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1 en = 1'b0;
        any_vld = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (vld) any_vld = 1'b1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush ready at T+11", 32'(rdy), 32'd1);
        check("flush result held", res, last_res);
        en = 1'b1; op = ALU_ADD; a = 32'd40; b = 32'd2;
        @(posedge clk);
        #1 en = 1'b0;
        @(negedge clk);
        if (vld) any_vld = any_vld;
        check("post-flush add valid", 32'(vld), 32'd1);
        check("post-flush add result", res, 32'd42);
        last_res = 32'd42;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (vld) any_vld = 1'b1;
        end
        check("flushed div no valid", 32'(any_vld), 32'd0);

        // Flush and enable together in IDLE: nothing accepted.
        @(negedge clk);
        en = 1'b1; flush = 1'b1; op = ALU_ADD; a = 32'd1; b = 32'd1;
        @(posedge clk);
        #1 en = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush+enable no valid", 32'(vld), 32'd0);
        check("flush+enable result held", res, last_res);

        // MUL_EN=0 instance: MUL is illegal, ADD still legal.
        @(negedge clk);
        en2 = 1'b1; op = ALU_MUL; a = 32'd7; b = 32'd3;
        @(posedge clk);
        #1 en2 = 1'b0;
        @(negedge clk);
        check("nomul mul valid", 32'(vld2), 32'd1);
        check("nomul mul illegal", 32'(ill2), 32'd1);
        check("nomul mul result", res2, 32'd0);
        check("nomul ready", 32'(rdy2), 32'd1);
        en2 = 1'b1; op = ALU_ADD; a = 32'd3; b = 32'd4;
        @(posedge clk);
        #1 en2 = 1'b0;
        @(negedge clk);
        check("nomul add illegal", 32'(ill2), 32'd0);
        check("nomul add result", res2, 32'd7);

        // Reset pulse mid-DIV.
        @(negedge clk);
        en = 1'b1; op = ALU_DIV; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        #1 en = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid reset result", res, 32'd0);
        check("mid reset ready", 32'(rdy), 32'd1);
        #2 reset = 1'b0;
        any_vld = 1'b0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (vld) any_vld = 1'b1;
        end
        check("reset div no valid", 32'(any_vld), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
